// File: rtl/universal_shift_register.sv
// universal_shift_register
//   Loadable register with hold, load, increment/decrement and multi-step
//   shift/rotate. Shift and rotate move one bit per clock. A step count of 2
//   or more keeps the block busy until the last step has been applied.
//
// Ports
//   CLK      rising-edge clock
//   RST_n    asynchronous active-low reset
//   Start    operation request, accepted only while idle
//   Mode     000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR,
//            110 INC, 111 DEC
//   Amt      step count for SHL/SHR/ROL/ROR
//   D        parallel load data
//   SerIn_L  bit entering the MSB on SHR
//   SerIn_R  bit entering the LSB on SHL
//   Q        register contents
//   Busy     multi-step operation in progress
//   Done     one-cycle completion pulse, registered
//   Cout     last bit shifted/rotated out, INC carry or DEC borrow
//   Zero     Q == 0
//
// State | meaning
// IDLE  | waiting for Start; single-cycle ops and the first step run here
// RUN   | applying the remaining steps of a shift/rotate

module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             Start,
  input  logic [2:0]       Mode,
  input  logic [AMT_W-1:0] Amt,
  input  logic [WIDTH-1:0] D,
  input  logic             SerIn_L,
  input  logic             SerIn_R,
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Done,
  output logic             Cout,
  output logic             Zero
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_INC  = 3'b110;
  localparam logic [2:0] M_DEC  = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic [2:0]       op_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_cout;
  logic             start_is_shift;

  // While idle the incoming Mode drives the step so the first step lands on
  // the accept edge; during RUN only the latched mode is used, so Mode/D
  // changes cannot disturb the operation in progress.
  assign op_mode = (state_q == IDLE) ? Mode : mode_q;

  assign start_is_shift = (Mode == M_SHL) || (Mode == M_SHR) ||
                          (Mode == M_ROL) || (Mode == M_ROR);

  always_comb begin
    step_q    = q_q;
    step_cout = cout_q;
    case (op_mode)
      M_HOLD: begin
        step_q    = q_q;
        step_cout = cout_q;
      end
      M_LOAD: begin
        step_q    = D;
        step_cout = cout_q;
      end
      M_SHL: begin
        step_q    = {q_q[WIDTH-2:0], SerIn_R};
        step_cout = q_q[WIDTH-1];
      end
      M_SHR: begin
        step_q    = {SerIn_L, q_q[WIDTH-1:1]};
        step_cout = q_q[0];
      end
      M_ROL: begin
        step_q    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        step_cout = q_q[WIDTH-1];
      end
      M_ROR: begin
        step_q    = {q_q[0], q_q[WIDTH-1:1]};
        step_cout = q_q[0];
      end
      M_INC: begin
        step_q    = q_q + WIDTH'(1);
        step_cout = &q_q;
      end
      M_DEC: begin
        step_q    = q_q - WIDTH'(1);
        step_cout = ~|q_q;
      end
      default: begin
        step_q    = q_q;
        step_cout = cout_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          mode_d = Mode;
          if (start_is_shift) begin
            if (Amt == '0) begin
              done_d = 1'b1;
            end else begin
              q_d    = step_q;
              cout_d = step_cout;
              if (Amt == AMT_W'(1)) begin
                done_d = 1'b1;
              end else begin
                // cnt holds the steps still to apply after the accept edge
                cnt_d   = Amt - AMT_W'(1);
                state_d = RUN;
              end
            end
          end else begin
            q_d    = step_q;
            cout_d = step_cout;
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        q_d    = step_q;
        cout_d = step_cout;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      mode_q  <= M_HOLD;
      cnt_q   <= '0;
      q_q     <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign Q    = q_q;
  assign Busy = (state_q == RUN);
  assign Done = done_q;
  assign Cout = cout_q;
  assign Zero = (q_q == '0);

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_INC  = 3'b110;
  localparam logic [2:0] M_DEC  = 3'b111;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic       Start;
  logic [2:0] Mode;
  logic [3:0] Amt;
  logic [7:0] D;
  logic       SerIn_L;
  logic       SerIn_R;
  logic [7:0] Q;
  logic       Busy;
  logic       Done;
  logic       Cout;
  logic       Zero;

  universal_shift_register #(.WIDTH(8), .AMT_W(4)) dut (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .Start   (Start),
    .Mode    (Mode),
    .Amt     (Amt),
    .D       (D),
    .SerIn_L (SerIn_L),
    .SerIn_R (SerIn_R),
    .Q       (Q),
    .Busy    (Busy),
    .Done    (Done),
    .Cout    (Cout),
    .Zero    (Zero)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] q;
    logic       cout;
    logic       busy;
    logic       done;
    string      tag;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_q;
  logic       m_cout;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference behaviour of one step, written from the operation table.
  task automatic model_step(input logic [2:0] md, input logic [7:0] d,
                            input logic sl, input logic sr);
    case (md)
      M_HOLD: ;
      M_LOAD: m_q = d;
      M_SHL: begin m_cout = m_q[7]; m_q = {m_q[6:0], sr}; end
      M_SHR: begin m_cout = m_q[0]; m_q = {sl, m_q[7:1]}; end
      M_ROL: begin m_cout = m_q[7]; m_q = {m_q[6:0], m_q[7]}; end
      M_ROR: begin m_cout = m_q[0]; m_q = {m_q[0], m_q[7:1]}; end
      M_INC: begin m_cout = (m_q == 8'hFF); m_q = m_q + 8'd1; end
      M_DEC: begin m_cout = (m_q == 8'h00); m_q = m_q - 8'd1; end
      default: ;
    endcase
  endtask

  task automatic push_exp(input string tag, input logic busy, input logic done);
    exp_t e;
    e.q    = m_q;
    e.cout = m_cout;
    e.busy = busy;
    e.done = done;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic tick_cmp();
    exp_t e;
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty: got no expected entry, required one at %0t", $time);
    end else begin
      e = sb.pop_front();
      check_val({e.tag, "_q"},    32'(Q),    32'(e.q));
      check_val({e.tag, "_cout"}, 32'(Cout), 32'(e.cout));
      check_val({e.tag, "_busy"}, 32'(Busy), 32'(e.busy));
      check_val({e.tag, "_done"}, 32'(Done), 32'(e.done));
      check_val({e.tag, "_zero"}, 32'(Zero), 32'(e.q == 8'h00));
    end
  endtask

  // Issue one operation and follow it to one idle cycle past its Done.
  // With poke set, Start is held high (with LOAD/D=0 on the bus) through RUN.
  task automatic run_op(input logic [2:0] md, input logic [3:0] amt, input logic [7:0] d,
                        input logic sl, input logic sr, input bit poke, input string tag);
    int n;
    bit sh;
    sh = (md == M_SHL) || (md == M_SHR) || (md == M_ROL) || (md == M_ROR);
    Start = 1'b1; Mode = md; Amt = amt; D = d; SerIn_L = sl; SerIn_R = sr;
    if (sh && amt == 4'd0) begin
      push_exp(tag, 1'b0, 1'b1);
      n = 1;
    end else if (!sh) begin
      model_step(md, d, sl, sr);
      push_exp(tag, 1'b0, 1'b1);
      n = 1;
    end else begin
      n = int'(amt);
      for (int i = 1; i <= n; i++) begin
        model_step(md, d, sl, sr);
        push_exp(tag, i < n, i == n);
      end
    end
    push_exp({tag, "_idle"}, 1'b0, 1'b0);
    for (int j = 1; j <= n + 1; j++) begin
      tick_cmp();
      Start = poke && (j < n);
      Mode  = M_LOAD;
      D     = 8'h00;
      Amt   = 4'hF;
    end
  endtask

  initial begin
    RST_n = 1'b0; Start = 1'b0; Mode = M_HOLD; Amt = 4'd0; D = 8'h00;
    SerIn_L = 1'b0; SerIn_R = 1'b0;
    m_q = 8'h00; m_cout = 1'b0;

    repeat (2) @(posedge CLK);
    #1;
    check_val("rst_q",    32'(Q),    32'h00);
    check_val("rst_busy", 32'(Busy), 32'h0);
    check_val("rst_done", 32'(Done), 32'h0);
    check_val("rst_cout", 32'(Cout), 32'h0);
    check_val("rst_zero", 32'(Zero), 32'h1);
    RST_n = 1'b1;

    run_op(M_LOAD, 4'd7, 8'hA5, 1'b0, 1'b0, 1'b0, "load_a5");
    check_val("load_a5_const", 32'(Q), 32'hA5);

    run_op(M_SHL, 4'd3, 8'h00, 1'b1, 1'b0, 1'b0, "shl3");
    check_val("shl3_const_q",    32'(Q),    32'h28);
    check_val("shl3_const_cout", 32'(Cout), 32'h1);

    run_op(M_LOAD, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, "load_a5b");
    run_op(M_ROR, 4'd4, 8'h33, 1'b1, 1'b1, 1'b1, "ror4_poke");
    check_val("ror4_const_q",    32'(Q),    32'h5A);
    check_val("ror4_const_cout", 32'(Cout), 32'h0);

    run_op(M_LOAD, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0, "load_ff");
    run_op(M_INC, 4'd5, 8'h00, 1'b0, 1'b0, 1'b0, "inc_wrap");
    check_val("inc_wrap_const_q", 32'(Q), 32'h00);
    run_op(M_DEC, 4'd5, 8'h00, 1'b0, 1'b0, 1'b0, "dec_wrap");
    check_val("dec_wrap_const_q", 32'(Q), 32'hFF);

    run_op(M_LOAD, 4'd0, 8'h3C, 1'b0, 1'b0, 1'b0, "load_3c");
    run_op(M_SHR, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, "shr0");
    check_val("shr0_const_q",    32'(Q),    32'h3C);
    check_val("shr0_const_cout", 32'(Cout), 32'h1);

    run_op(M_SHR, 4'd1, 8'h00, 1'b1, 1'b0, 1'b0, "shr1");
    check_val("shr1_const_q", 32'(Q), 32'h9E);
    run_op(M_SHL, 4'd2, 8'h00, 1'b0, 1'b1, 1'b0, "shl2");
    run_op(M_ROL, 4'd5, 8'h00, 1'b0, 1'b0, 1'b0, "rol5");
    run_op(M_HOLD, 4'd3, 8'h77, 1'b0, 1'b0, 1'b0, "hold");
    run_op(M_SHR, 4'd15, 8'h00, 1'b1, 1'b0, 1'b0, "shr15");

    // Back-to-back accepts: Start held across two edges, second one lands
    // in the cycle where Done is high.
    run_op(M_LOAD, 4'd0, 8'h10, 1'b0, 1'b0, 1'b0, "load_10");
    Start = 1'b1; Mode = M_INC;
    model_step(M_INC, 8'h00, 1'b0, 1'b0);
    push_exp("b2b_1", 1'b0, 1'b1);
    model_step(M_INC, 8'h00, 1'b0, 1'b0);
    push_exp("b2b_2", 1'b0, 1'b1);
    push_exp("b2b_idle", 1'b0, 1'b0);
    tick_cmp();
    tick_cmp();
    Start = 1'b0;
    tick_cmp();
    check_val("b2b_const_q", 32'(Q), 32'h12);

    // Reset in the middle of a long rotate.
    run_op(M_LOAD, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0, "load_81");
    Start = 1'b1; Mode = M_ROL; Amt = 4'd8;
    for (int i = 1; i <= 3; i++) begin
      model_step(M_ROL, 8'h00, 1'b0, 1'b0);
      push_exp("rol8_pre", 1'b1, 1'b0);
    end
    tick_cmp();
    Start = 1'b0;
    tick_cmp();
    tick_cmp();
    check_val("rol8_pre_const_q", 32'(Q), 32'h0C);
    RST_n = 1'b0;
    #1;
    check_val("midrst_q",    32'(Q),    32'h00);
    check_val("midrst_busy", 32'(Busy), 32'h0);
    check_val("midrst_done", 32'(Done), 32'h0);
    check_val("midrst_cout", 32'(Cout), 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    check_val("midrst_hold_done", 32'(Done), 32'h0);
    RST_n = 1'b1;
    m_q = 8'h00; m_cout = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_exp("post_rst", 1'b0, 1'b0);
      tick_cmp();
    end

    run_op(M_LOAD, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, "post_rst_load");

    check_val("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, 8, register width in bits (legal 2..32).
REQ-002 Parameter AMT_W SHALL be: AMT_W, 4, width of the step-count input.
REQ-003 The design SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- CLK  input  1  rising-edge clock.
- RST_n  input  1  asynchronous active-low reset.
- Start  input  1  operation request, sampled on CLK rise.
- Mode  input  3  operation code: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 INC, 111 DEC.
- Amt  input  AMT_W  step count for SHL/SHR/ROL/ROR.
- D  input  WIDTH  parallel load data.
- SerIn_L  input  1  serial bit entering the MSB on SHR.
- SerIn_R  input  1  serial bit entering the LSB on SHL.
- Q  output  WIDTH  register contents.
- Busy  output  1  multi-step operation in progress.
- Done  output  1  one-cycle completion pulse.
- Cout  output  1  last bit shifted or rotated out, or INC carry / DEC borrow.
- Zero  output  1  Q equals 0 (combinational from Q).

Function
REQ-004 The FSM SHALL have two states, IDLE and RUN; Busy SHALL be 1 exactly in RUN.
REQ-005 A Start is accepted only on a CLK rise in IDLE; in RUN, Start SHALL be ignored with no effect on Q, Mode, or the count.
REQ-006 On acceptance the block SHALL latch Mode and Amt and execute the first step on that same edge.
REQ-007 Single-cycle operations SHALL behave as follows:
- HOLD: Q unchanged.
- LOAD: Q <= D.
- INC: Q <= Q+1 modulo 2^WIDTH.
- DEC: Q <= Q-1 modulo 2^WIDTH.
- Amt is ignored for all four.
- FSM stays in IDLE.
- Done = 1 in the following cycle.
REQ-008 Shift and rotate steps SHALL be:
- SHL: Q <= {Q[WIDTH-2:0], SerIn_R}, Cout <= Q[WIDTH-1].
- SHR: Q <= {SerIn_L, Q[WIDTH-1:1]}, Cout <= Q[0].
- ROL: Cout <= Q[WIDTH-1].
- ROR: Cout <= Q[0].
- Serial inputs are sampled at each step edge.
REQ-009 For a shift or rotate with Amt = k:
- k = 0: Q and Cout unchanged, stays IDLE, Done next cycle.
- k = 1: one step on the accept edge, stays IDLE, Done next cycle.
- k >= 2: steps on k consecutive edges starting at the accept edge; enter RUN after the accept edge; Busy = 1 for k-1 cycles; return to IDLE on the k-th step edge; Done = 1 in the cycle after it.
REQ-010 Cout SHALL be:
- INC: 1 iff Q was all-ones.
- DEC: 1 iff Q was 0.
- LOAD/HOLD: unchanged.
- Cout holds its value between operations.
REQ-011 Done SHALL be a registered pulse exactly one cycle wide; back-to-back accepts SHALL give back-to-back Done pulses.
REQ-012 A Start accepted in the cycle Done is high SHALL be legal and processed normally.
REQ-013 D and Mode changes during RUN SHALL NOT affect the operation in progress.

Reset
REQ-014 RST_n = 0 SHALL immediately force:
- Q = 0, Busy = 0, Done = 0, Cout = 0.
- FSM = IDLE, step counter = 0.
- This holds regardless of CLK.
REQ-015 Reset asserted mid-RUN SHALL abort the operation; no Done is issued for it.
REQ-016 After RST_n deasserts, the first CLK rise with Start = 1 SHALL be accepted.

Verification (WIDTH=8, AMT_W=4)
REQ-017 LOAD: D=A5, Start → Q=A5 after the edge, Done=1 for one cycle, Zero=0, Busy never 1.
REQ-018 SHL: Q=A5, Amt=3, SerIn_R=0 → Q=4A, 94, 28 on three successive edges; Busy=1 for 2 cycles; Cout=1; Done after the third edge.
REQ-019 ROR: Q=A5, Amt=4 → Q=D2, 69, B4, 5A; Cout=0; a Start pulsed during Busy is ignored (Q ends 5A, single Done).
REQ-020 Wrap-around:
- INC with Q=FF → Q=00, Cout=1, Zero=1.
- Then DEC → Q=FF, Cout=1, Zero=0.
REQ-021 Reset mid-op: ROL Amt=8 on Q=81, RST_n=0 after the 3rd step → Q=00, Busy=0, Done=0 immediately; no Done after release.
REQ-022 Amt=0 SHR on Q=3C → Q=3C, Cout unchanged, Done=1 next cycle.
